// File: rtl/vram_arbiter.sv
// Single-port video/data RAM arbiter: interleaves CPU req/ack accesses with
// row-at-a-time video prefetch into a small FIFO feeding the VGA scan-out.
module vram_arbiter #(
   parameter int AW            = 7,
   parameter int DW            = 32,
   parameter int FIFO_DEPTH    = 4,
   parameter int WORDS_PER_ROW = 5
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          vid_line_start,
   input  logic [3:0]    vid_row,
   input  logic          vid_pop,
   output logic [DW-1:0] vid_data,
   output logic          vid_empty,
   output logic          vid_underflow,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int RW = $clog2(WORDS_PER_ROW + 1);

   // State names what was issued in the previous cycle; S_CPU is the ack cycle.
   typedef enum logic [1:0] {S_IDLE, S_VID, S_CPU} state_t;

   state_t          state_q, state_d;
   logic            last_vid_q, last_vid_d;
   logic            cpu_we_q, cpu_we_d;
   logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic [AW-1:0]   row_base_q, row_base_d;
   logic [RW-1:0]   idx_q, idx_d;
   logic [RW-1:0]   remaining_q, remaining_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [DW-1:0]   last_q, last_d;
   logic            underflow_q, underflow_d;
   logic [DW-1:0]   fifo_mem_q [FIFO_DEPTH];

   logic [CW-1:0]   fifo_level;
   logic            vid_elig, cpu_elig, gnt_vid, gnt_cpu;
   logic            push, pop;
   logic [AW-1:0]   vid_addr;

   // Grant decision for this cycle
   always_comb begin
      fifo_level = count_q + CW'(state_q == S_VID);
      vid_elig   = reset_n && !vid_line_start && (remaining_q != '0)
                   && (fifo_level < CW'(FIFO_DEPTH));
      cpu_elig   = reset_n && cpu_req && (state_q != S_CPU);
      gnt_vid    = 1'b0;
      gnt_cpu    = 1'b0;
      if (vid_elig && (fifo_level < CW'(2))) begin
         gnt_vid = 1'b1;
      end else if (vid_elig && cpu_elig) begin
         if (last_vid_q) gnt_cpu = 1'b1;
         else            gnt_vid = 1'b1;
      end else if (cpu_elig) begin
         gnt_cpu = 1'b1;
      end else if (vid_elig) begin
         gnt_vid = 1'b1;
      end
   end

   assign vid_addr  = row_base_q + AW'(idx_q);
   assign mem_en    = gnt_vid | gnt_cpu;
   assign mem_we    = gnt_cpu & cpu_we;
   assign mem_addr  = gnt_cpu ? cpu_addr : (gnt_vid ? vid_addr : '0);
   assign mem_wdata = gnt_cpu ? cpu_wdata : '0;

   assign cpu_ack   = (state_q == S_CPU);
   assign cpu_rdata = (cpu_ack && !cpu_we_q) ? mem_rdata : cpu_rdata_q;

   assign vid_empty     = (count_q == '0);
   assign vid_data      = vid_empty ? last_q : fifo_mem_q[rd_ptr_q];
   assign vid_underflow = underflow_q;

   // Returning video data is dropped in a line-start cycle; it belongs to the old row.
   assign push = (state_q == S_VID) && !vid_line_start;
   assign pop  = vid_pop && !vid_empty && !vid_line_start;

   always_comb begin
      state_d     = gnt_cpu ? S_CPU : (gnt_vid ? S_VID : S_IDLE);
      last_vid_d  = gnt_vid ? 1'b1 : (gnt_cpu ? 1'b0 : last_vid_q);
      cpu_we_d    = gnt_cpu ? cpu_we : cpu_we_q;
      cpu_rdata_d = cpu_rdata;
      row_base_d  = row_base_q;
      idx_d       = idx_q;
      remaining_d = remaining_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      last_d      = pop ? fifo_mem_q[rd_ptr_q] : last_q;
      underflow_d = underflow_q | (vid_pop && vid_empty && !vid_line_start);
      if (vid_line_start) begin
         row_base_d  = AW'(vid_row) * AW'(WORDS_PER_ROW);
         idx_d       = '0;
         remaining_d = RW'(WORDS_PER_ROW);
         rd_ptr_d    = '0;
         wr_ptr_d    = '0;
         count_d     = '0;
      end else begin
         if (gnt_vid) begin
            idx_d       = idx_q + RW'(1);
            remaining_d = remaining_q - RW'(1);
         end
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         last_vid_q  <= 1'b0;
         cpu_we_q    <= 1'b0;
         cpu_rdata_q <= '0;
         row_base_q  <= '0;
         idx_q       <= '0;
         remaining_q <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         last_q      <= '0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_vid_q  <= last_vid_d;
         cpu_we_q    <= cpu_we_d;
         cpu_rdata_q <= cpu_rdata_d;
         row_base_q  <= row_base_d;
         idx_q       <= idx_d;
         remaining_q <= remaining_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         last_q      <= last_d;
         underflow_q <= underflow_d;
      end
   end

   // FIFO storage carries data only; occupancy is tracked by the pointers above.
   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= mem_rdata;
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: behavioural RAM, shadow memory model,
// expected-response queues popped by an independent monitor.
module tb_vram_arbiter;
   localparam int AW  = 7;
   localparam int DW  = 32;
   localparam int WPR = 5;
   localparam int NW  = 128;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cpu_req, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_ack;
   logic [DW-1:0] cpu_rdata;
   logic          vid_line_start;
   logic [3:0]    vid_row;
   logic          vid_pop;
   logic [DW-1:0] vid_data;
   logic          vid_empty, vid_underflow;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   vram_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .vid_line_start(vid_line_start), .vid_row(vid_row), .vid_pop(vid_pop),
      .vid_data(vid_data), .vid_empty(vid_empty), .vid_underflow(vid_underflow),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM seen by the DUT
   logic [DW-1:0] ram [NW];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   // Reference model: what the memory should contain from the CPU's point of view
   logic [DW-1:0] shadow [NW];

   typedef struct {logic we; logic [DW-1:0] data;} cpu_exp_t;
   cpu_exp_t      cpu_exp [$];
   logic [DW-1:0] vid_exp [$];
   int            vid_log [$];
   int            pop_mode = 0;
   int            n_checks = 0;
   int            n_fail   = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_event(input string name, input int val);
      n_checks++;
      n_fail++;
      $display("FAIL %s: observed value %0d where none was expected", name, val);
   endtask

   // Pop driver
   initial begin
      vid_pop = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (pop_mode)
            1: vid_pop = !vid_empty;
            2: vid_pop = !vid_empty && ($urandom_range(0, 1) == 1);
            3: begin vid_pop = 1'b1; pop_mode = 0; end
            default: vid_pop = 1'b0;
         endcase
      end
   end

   // Monitor
   initial begin
      cpu_exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (vid_pop && !vid_empty && !vid_line_start) begin
               if (vid_exp.size() == 0) fail_event("vid_extra_word", int'(vid_data));
               else check("vid_data", vid_data, vid_exp.pop_front());
            end
            if (cpu_ack) begin
               if (cpu_exp.size() == 0) fail_event("cpu_ack_unexpected", 1);
               else begin
                  e = cpu_exp.pop_front();
                  if (!e.we) check("cpu_rdata", cpu_rdata, e.data);
               end
            end
            if (mem_en && !(cpu_req && mem_addr == cpu_addr && mem_we == cpu_we))
               vid_log.push_back(int'(mem_addr));
         end
      end
   end

   task automatic ls_begin(input int r);
      vid_line_start = 1'b1;
      vid_row = 4'(r);
      vid_exp.delete();
      for (int i = 0; i < WPR; i++) vid_exp.push_back(shadow[(r * WPR + i) % NW]);
   endtask

   task automatic line_start(input int r);
      @(posedge clk); #1;
      ls_begin(r);
      @(posedge clk); #1;
      vid_line_start = 1'b0;
   endtask

   task automatic cpu_access(input logic we, input int a, input logic [DW-1:0] d,
                             input int bound, output int lat);
      cpu_exp_t e;
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = AW'(a); cpu_wdata = d;
      e.we = we;
      e.data = we ? d : shadow[a];
      if (we) shadow[a] = d;
      cpu_exp.push_back(e);
      lat = 0;
      forever begin
         @(negedge clk);
         if (cpu_ack) break;
         lat++;
         if (lat > bound) begin
            fail_event("cpu_ack_timeout", lat);
            void'(cpu_exp.pop_back());
            break;
         end
      end
      @(posedge clk); #1;
      cpu_req = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_cpu_ack"}, cpu_ack, 0);
      check({tag, "_cpu_rdata"}, cpu_rdata, 0);
      check({tag, "_mem_en"}, mem_en, 0);
      check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_mem_wdata"}, mem_wdata, 0);
      check({tag, "_vid_data"}, vid_data, 0);
      check({tag, "_vid_empty"}, vid_empty, 1);
      check({tag, "_vid_underflow"}, vid_underflow, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      reset_n = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      vid_line_start = 1'b0; vid_row = '0;
      for (int i = 0; i < NW; i++) ram[i] = $urandom;
      for (int i = 0; i < WPR; i++) ram[15 + i] = 32'hA + i;
      for (int i = 0; i < NW; i++) shadow[i] = ram[i];

      // Reset state
      repeat (3) @(posedge clk);
      #1 check_idle_outputs("in_reset");
      reset_n = 1'b1;
      @(negedge clk);
      check_idle_outputs("after_reset");

      // Row 3 fetch with continuous popping
      pop_mode = 1;
      vid_log.delete();
      line_start(3);
      repeat (20) @(negedge clk);
      check("row3_read_count", vid_log.size(), WPR);
      for (int i = 0; i < WPR && i < vid_log.size(); i++) check("row3_addr", vid_log[i], 15 + i);
      check("row3_all_popped", vid_exp.size(), 0);
      check("row3_vid_data_hold", vid_data, 32'hE);
      check("row3_no_underflow", vid_underflow, 0);

      // Stall at full FIFO, CPU write while full, single pop resumes
      pop_mode = 0;
      vid_log.delete();
      line_start(3);
      repeat (15) @(negedge clk);
      check("stall_read_count", vid_log.size(), 4);
      for (int i = 0; i < 4 && i < vid_log.size(); i++) check("stall_addr", vid_log[i], 15 + i);
      check("stall_head", vid_data, 32'hA);
      cpu_access(1'b1, 32'h20, 32'hDEADBEEF, 3, lat);
      check("cpu_wr_latency_full", lat, 1);
      pop_mode = 3;
      repeat (8) @(negedge clk);
      check("resume_read_count", vid_log.size(), 5);
      if (vid_log.size() == 5) check("resume_addr", vid_log[4], 19);
      check("resume_head", vid_data, 32'hB);
      cpu_access(1'b0, 32'h20, '0, 3, lat);
      check("cpu_rd_latency", lat, 1);

      // Line start one cycle after a video read is issued
      pop_mode = 0;
      line_start(3);
      @(negedge clk);
      check("issue_mem_en", mem_en, 1);
      check("issue_mem_addr", mem_addr, 15);
      @(posedge clk); #1;
      ls_begin(7);
      vid_log.delete();
      @(posedge clk); #1;
      vid_line_start = 1'b0;
      check("flush_empty", vid_empty, 1);
      pop_mode = 1;
      repeat (20) @(negedge clk);
      check("row7_read_count", vid_log.size(), WPR);
      for (int i = 0; i < WPR && i < vid_log.size(); i++) check("row7_addr", vid_log[i], 35 + i);
      check("row7_all_popped", vid_exp.size(), 0);
      check("row7_last_word", vid_data, shadow[39]);

      // Underflow is sticky across line starts
      pop_mode = 0;
      repeat (2) @(negedge clk);
      check("pre_underflow_empty", vid_empty, 1);
      pop_mode = 3;
      repeat (3) @(negedge clk);
      check("underflow_set", vid_underflow, 1);
      line_start(2);
      repeat (10) @(negedge clk);
      check("underflow_sticky", vid_underflow, 1);

      // Reset in the middle of a CPU read
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'd5;
      @(negedge clk);
      check("abort_read_granted", mem_en, 1);
      #1 reset_n = 1'b0;
      #2 check_idle_outputs("abort_reset");
      vid_exp.delete();
      repeat (2) @(negedge clk);
      check("abort_no_ack", cpu_ack, 0);
      cpu_req = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check_idle_outputs("abort_release");

      // Randomised traffic
      fork
         begin
            for (int k = 0; k < 40; k++) begin
               if ($urandom_range(0, 1) == 1)
                  cpu_access(1'b1, 80 + $urandom_range(0, 47), $urandom, 40, lat);
               else
                  cpu_access(1'b0, $urandom_range(0, NW - 1), '0, 40, lat);
               repeat ($urandom_range(0, 2)) @(posedge clk);
            end
         end
         begin
            for (int k = 0; k < 12; k++) begin
               pop_mode = 1 + $urandom_range(0, 1);
               line_start($urandom_range(0, 15));
               repeat (10 + $urandom_range(0, 19)) @(posedge clk);
            end
         end
      join
      pop_mode = 1;
      repeat (30) @(negedge clk);
      check("rand_vid_drained", vid_exp.size(), 0);
      check("rand_cpu_drained", cpu_exp.size(), 0);
      check("rand_no_underflow", vid_underflow, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
